// File: rtl/c1541_track_ctrl.sv
// ---------------------------------------------------------------------------
// c1541_track_ctrl
//
// Head-position tracker and track-buffer controller for a 1541-style drive.
// The stepper phases from the drive VIA are decoded into a half-track
// position (0..83). Once the head has been quiet for SETTLE_TICKS drive
// ticks, the controller writes back a dirty buffer and/or loads the
// half-track under the head through a simple req/ack storage handshake.
//
// Ports
//   clk          in   system clock (single domain)
//   reset_n      in   asynchronous active-low reset
//   ce           in   1 MHz drive clock enable; stepping and settle timing
//   stp[1:0]     in   stepper phase
//   mtr          in   spindle motor on
//   wr_strobe    in   drive wrote a byte into the track buffer
//   img_change   in   a new disk image was mounted
//   sd_ack       in   storage side completes the current request
//   sd_req       out  transfer request level
//   sd_wr        out  1 = write back buffer, 0 = load buffer
//   sd_htrack    out  half-track of the transfer
//   half_track   out  current head half-track
//   tr00_sense_n out  low when the head is on half-track 0
//   busy         out  controller is not idle
//   trk_valid    out  buffer holds the half-track under the head
// ---------------------------------------------------------------------------
module c1541_track_ctrl #(
    parameter int SETTLE_TICKS = 2048,
    parameter int START_HTRACK = 34
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       wr_strobe,
    input  logic       img_change,
    input  logic       sd_ack,
    output logic       sd_req,
    output logic       sd_wr,
    output logic [6:0] sd_htrack,
    output logic [6:0] half_track,
    output logic       tr00_sense_n,
    output logic       busy,
    output logic       trk_valid
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_LOAD      = 2'd3
    } state_t;

    localparam logic [6:0]  NO_TRACK    = 7'h7F;
    localparam logic [6:0]  MAX_HTRACK  = 7'd83;
    localparam logic [6:0]  START_TRACK = 7'(START_HTRACK);
    localparam logic [11:0] SETTLE_LOAD = 12'(SETTLE_TICKS);

    state_t      state_q, state_d;
    logic [6:0]  half_track_q, half_track_d;
    logic [1:0]  prev_stp_q, prev_stp_d;
    logic [6:0]  loaded_q, loaded_d;
    logic        dirty_q, dirty_d;
    logic        reload_q, reload_d;
    logic [11:0] cnt_q, cnt_d;
    logic        sd_req_q, sd_req_d;
    logic        sd_wr_q, sd_wr_d;
    logic [6:0]  sd_htrack_q, sd_htrack_d;

    logic [1:0]  phase_diff_s;
    logic        move_s;
    logic        ack_ok_s;
    logic        mismatch_s;
    logic        buf_open_s;

    assign ack_ok_s   = sd_ack & sd_req_q;
    assign mismatch_s = (half_track_q != loaded_q);
    assign buf_open_s = (state_q == ST_IDLE) || (state_q == ST_SETTLE);

    // Stepper decode: +1 phase steps in, -1 phase steps out, 0/2 ignored.
    // A saturated step does not count as a move.
    always_comb begin
        half_track_d = half_track_q;
        prev_stp_d   = prev_stp_q;
        move_s       = 1'b0;
        phase_diff_s = stp - prev_stp_q;
        if (ce && mtr) begin
            prev_stp_d = stp;
            case (phase_diff_s)
                2'd1: begin
                    if (half_track_q != MAX_HTRACK) begin
                        half_track_d = half_track_q + 7'd1;
                        move_s       = 1'b1;
                    end else begin
                        half_track_d = half_track_q;
                    end
                end
                2'd3: begin
                    if (half_track_q != 7'd0) begin
                        half_track_d = half_track_q - 7'd1;
                        move_s       = 1'b1;
                    end else begin
                        half_track_d = half_track_q;
                    end
                end
                default: half_track_d = half_track_q;
            endcase
        end else begin
            prev_stp_d = prev_stp_q;
        end
    end

    // Buffer bookkeeping: dirty flag, loaded half-track, and the reload flag
    // that forces a fresh load when the image changes under a running load.
    always_comb begin
        if (img_change) begin
            dirty_d = 1'b0;
        end else if ((state_q == ST_WRITEBACK) && ack_ok_s) begin
            dirty_d = 1'b0;
        end else if (wr_strobe && (loaded_q != NO_TRACK) && buf_open_s) begin
            dirty_d = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end

        if (img_change) begin
            loaded_d = NO_TRACK;
        end else if ((state_q == ST_LOAD) && ack_ok_s) begin
            loaded_d = reload_q ? NO_TRACK : sd_htrack_q;
        end else begin
            loaded_d = loaded_q;
        end

        if (state_q == ST_LOAD) begin
            if (ack_ok_s) begin
                reload_d = 1'b0;
            end else if (img_change) begin
                reload_d = 1'b1;
            end else begin
                reload_d = reload_q;
            end
        end else begin
            reload_d = 1'b0;
        end
    end

    // Transfer FSM next state, settle counter and registered request outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (move_s || mismatch_s || (dirty_q && !mtr)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (move_s) begin
                    cnt_d = SETTLE_LOAD;
                end else if (cnt_q == 12'd0) begin
                    // A write-back to an image that is being swapped out
                    // this very cycle is suppressed.
                    if (dirty_q && !img_change) begin
                        state_d = ST_WRITEBACK;
                    end else if (mismatch_s) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ce) begin
                    cnt_d = cnt_q - 12'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WRITEBACK: begin
                if (ack_ok_s) begin
                    state_d = mismatch_s ? ST_LOAD : ST_IDLE;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_LOAD: begin
                if (ack_ok_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 12'd0;
            end
        endcase

        // The request always drops for at least one cycle after an honoured
        // ack, so a write-back followed by a load shows two distinct requests.
        sd_req_d = !ack_ok_s && ((state_d == ST_WRITEBACK) || (state_d == ST_LOAD));
        sd_wr_d  = !ack_ok_s && (state_d == ST_WRITEBACK);

        if ((state_d == ST_WRITEBACK) && (state_q != ST_WRITEBACK)) begin
            sd_htrack_d = loaded_q;
        end else if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            sd_htrack_d = half_track_d;
        end else begin
            sd_htrack_d = sd_htrack_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            half_track_q <= START_TRACK;
            prev_stp_q   <= 2'd0;
            loaded_q     <= NO_TRACK;
            dirty_q      <= 1'b0;
            reload_q     <= 1'b0;
            cnt_q        <= 12'd0;
            sd_req_q     <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_htrack_q  <= 7'd0;
        end else begin
            state_q      <= state_d;
            half_track_q <= half_track_d;
            prev_stp_q   <= prev_stp_d;
            loaded_q     <= loaded_d;
            dirty_q      <= dirty_d;
            reload_q     <= reload_d;
            cnt_q        <= cnt_d;
            sd_req_q     <= sd_req_d;
            sd_wr_q      <= sd_wr_d;
            sd_htrack_q  <= sd_htrack_d;
        end
    end

    assign sd_req       = sd_req_q;
    assign sd_wr        = sd_wr_q;
    assign sd_htrack    = sd_htrack_q;
    assign half_track   = half_track_q;
    assign tr00_sense_n = (half_track_q != 7'd0);
    assign busy         = (state_q != ST_IDLE);
    assign trk_valid    = buf_open_s && (half_track_q == loaded_q);

endmodule

// File: doc/c1541_track_ctrl.md
C1541_TRACK_CTRL -- requirements
Module: c1541_track_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_TICKS, default 2048, meaning the number of ce ticks of head quiet time before a buffer transfer starts (range 1..4095).
REQ-002 SHALL have parameter START_HTRACK, default 34, meaning the head half-track after reset (track 18).
REQ-003 SHALL have ports:
- clk, in, 1: system clock; one clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- ce, in, 1: 1 MHz drive clock enable; all stepping and settle timing advances only when ce=1.
- stp, in, 2: stepper phase from the drive VIA.
- mtr, in, 1: spindle motor on (1).
- wr_strobe, in, 1: single-cycle pulse when the drive writes a byte into the track buffer.
- img_change, in, 1: single-cycle pulse when a new disk image is mounted.
- sd_ack, in, 1: single-cycle pulse from the storage side; completes the current request.
- sd_req, out, 1: transfer request, held as a level.
- sd_wr, out, 1: 1 = write back buffer, 0 = load buffer; valid while sd_req=1.
- sd_htrack, out, 7: half-track of the transfer; valid while sd_req=1.
- half_track, out, 7: current head position, 0..83.
- tr00_sense_n, out, 1: 0 when half_track==0.
- busy, out, 1: controller state is not IDLE.
- trk_valid, out, 1: buffer holds the half-track under the head.

Function
REQ-004 SHALL store the previous phase prev_stp; a step is evaluated only when ce=1 and mtr=1.
REQ-005 On a step, stp==prev_stp+1 (mod 4) SHALL increment half_track, saturating at 83.
REQ-006 On a step, stp==prev_stp-1 (mod 4) SHALL decrement half_track, saturating at 0.
REQ-007 On a step, a phase difference of 0 or 2 SHALL leave half_track unchanged.
REQ-008 prev_stp SHALL update to stp on every ce tick with mtr=1; with mtr=0 both prev_stp and half_track hold.
REQ-009 A "move" SHALL mean half_track actually changed; a saturated step is not a move.
REQ-010 A dirty flag SHALL set on wr_strobe whenever loaded_htrack is valid and state is IDLE or SETTLE; wr_strobe in any other state is ignored.
REQ-011 loaded_htrack SHALL be a 7-bit register; value 7'h7F means no valid buffer.
REQ-012 The FSM SHALL have states IDLE, SETTLE, WRITEBACK, LOAD.
REQ-013 IDLE -> SETTLE with the settle counter loaded to SETTLE_TICKS when any of these occurs:
- a move;
- half_track != loaded_htrack;
- dirty=1 and mtr=0.
REQ-014 SETTLE: a move SHALL reload the counter; each ce tick decrements it. At 0:
- dirty=1 -> WRITEBACK;
- else half_track != loaded_htrack -> LOAD;
- else -> IDLE.
REQ-015 WRITEBACK SHALL drive sd_req=1, sd_wr=1, sd_htrack=loaded_htrack. On sd_ack it SHALL clear dirty and go to LOAD if half_track != loaded_htrack, otherwise to IDLE.
REQ-016 LOAD SHALL latch half_track into sd_htrack on entry and drive sd_req=1, sd_wr=0. On sd_ack it SHALL set loaded_htrack to the latched value and go to IDLE.
REQ-017 sd_req, sd_wr and sd_htrack SHALL be registered and SHALL rise the cycle after state entry.
REQ-018 sd_ack is honoured only when sd_req=1 in that cycle; otherwise it is ignored.
REQ-019 sd_req SHALL drop the cycle after an honoured sd_ack.
REQ-020 Moves during WRITEBACK or LOAD SHALL still update half_track. The mismatch then re-triggers SETTLE from IDLE, giving a fresh settle period.
REQ-021 img_change SHALL have the following effect:
- clear dirty (no write-back to the new image);
- set loaded_htrack to 7'h7F;
- if in LOAD, set a reload flag so that completion leaves loaded_htrack at 7'h7F (forcing a fresh LOAD);
- if in WRITEBACK, leave the transfer to complete.
REQ-022 trk_valid SHALL be 1 iff state is IDLE or SETTLE and half_track==loaded_htrack.
REQ-023 busy and tr00_sense_n SHALL be registered, or combinational from registers only.

Reset
REQ-024 On reset_n=0, the following values SHALL apply:
- half_track=START_HTRACK, prev_stp=0;
- loaded_htrack=7'h7F, dirty=0;
- FSM=IDLE, settle counter=0;
- sd_req=0, sd_wr=0, sd_htrack=0;
- tr00_sense_n=1, trk_valid=0, busy=0.
REQ-025 Reset mid-transfer SHALL abandon the request with no write-back. After release, the FSM enters SETTLE on the next cycle (mismatch 34 vs 7F).

Verification
REQ-026 Reset, mtr=1, stp held: SETTLE for 2048 ce ticks -> LOAD with sd_req=1, sd_wr=0, sd_htrack=34. Ack -> trk_valid=1, busy=0.
REQ-027 Loaded at 34, stp sequence 0,1,2,3,0 on successive ce ticks -> half_track=38. Exactly one LOAD with sd_htrack=38, starting 2048 ticks after the last move.
REQ-028 At half_track=1, two down-steps -> half_track=0 and tr00_sense_n=0; a further down-step -> still 0, no move, no new SETTLE.
REQ-029 Loaded at 34, three wr_strobe, then step to 36 -> WRITEBACK with sd_htrack=34, sd_wr=1. Ack -> dirty=0, then LOAD with sd_htrack=36.
REQ-030 img_change during LOAD of 36 -> after ack loaded_htrack=7F and trk_valid=0; a second LOAD of 36 follows with no WRITEBACK.
REQ-031 Stray sd_ack in IDLE -> no state change. mtr=0 with steps applied -> half_track unchanged.
